// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory sequencer:
// state encoding and the default access timeout.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts ACCESS cycles; expired flags the last allowed cycle without an ack.
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Cycle counter, cleared while idle and advanced while an access is open
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: drives a multi-cycle data memory over req/ack,
// stalls the pipeline while an access is open and raises the branch flush.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic              Zero,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              flush,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              mem_err
);

    state_e            r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdata_valid;
    logic              r_mem_err;

    logic w_is_idle;
    logic w_is_access;
    logic w_one_op;
    logic w_both_op;
    logic w_expired;

    assign w_is_idle   = (r_state == ST_IDLE);
    assign w_is_access = (r_state == ST_ACCESS);
    assign w_one_op    = MemRead ^ MemWrite;
    assign w_both_op   = MemRead & MemWrite;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_is_idle),
        .enable  (w_is_access),
        .expired (w_expired)
    );

    // Access sequencer with registered memory-side and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_mem_err     <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_mem_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_one_op) begin
                        r_mem_addr  <= addr;
                        r_mem_wdata <= wdata;
                        r_mem_we    <= MemWrite;
                        r_mem_req   <= 1'b1;
                        r_state     <= ST_ACCESS;
                    end else if (w_both_op) begin
                        r_mem_err <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    // An ack on the final allowed cycle still counts as success
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            r_rdata       <= mem_rdata;
                            r_rdata_valid <= 1'b1;
                        end
                        r_mem_req <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (w_expired) begin
                        r_mem_err <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall = (w_is_idle & w_one_op) | w_is_access;
    assign flush = w_is_idle & Branch & Zero & ~MemRead & ~MemWrite;

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign mem_err     = r_mem_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with hand-computed expectations.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, Branch, Zero;
    logic [31:0] addr, wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall, flush;
    logic [31:0] rdata;
    logic        rdata_valid, mem_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_stall, n_req, n_valid, n_err, n_bad, n_flush;

    dmem_access_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Branch      (Branch),
        .Zero        (Zero),
        .addr        (addr),
        .wdata       (wdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .flush       (flush),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One memory op; ack on the ack_n-th request cycle (0 = never). Branch/Zero
    // held high throughout, so any flush seen here is an error.
    task automatic run_op(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                          input int ack_n, input logic [31:0] rdat);
        logic done;
        done     = 1'b0;
        n_stall  = 0; n_req = 0; n_valid = 0; n_err = 0; n_bad = 0; n_flush = 0;
        MemRead  = rd;
        MemWrite = !rd;
        addr     = a;
        wdata    = wd;
        Branch   = 1'b1;
        Zero     = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (mem_req) n_req++;
            mem_ack   = mem_req && (n_req == ack_n);
            mem_rdata = rdat;
            @(negedge clk);
            if (stall) n_stall++; else done = 1'b1;
            if (flush) n_flush++;
            if (rdata_valid) n_valid++;
            if (mem_err) n_err++;
            if (mem_req && (mem_addr !== a || mem_wdata !== wd || mem_we !== !rd)) n_bad++;
            step();
            if (done) begin
                MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0; Zero = 1'b0; mem_ack = 1'b0;
            end
        end
        if (!done) check_eq("op_bound", 64'd0, 64'd1);
        @(negedge clk);
        if (stall) n_stall++;
        if (rdata_valid) n_valid++;
        if (mem_err) n_err++;
        step();
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0; Zero = 1'b0;
        addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mem_req",     64'(mem_req),     64'd0);
        check_eq("rst_mem_we",      64'(mem_we),      64'd0);
        check_eq("rst_mem_addr",    64'(mem_addr),    64'd0);
        check_eq("rst_mem_wdata",   64'(mem_wdata),   64'd0);
        check_eq("rst_rdata",       64'(rdata),       64'd0);
        check_eq("rst_rdata_valid", 64'(rdata_valid), 64'd0);
        check_eq("rst_mem_err",     64'(mem_err),     64'd0);
        check_eq("rst_stall",       64'(stall),       64'd0);
        check_eq("rst_flush",       64'(flush),       64'd0);
        step();

        run_op(1'b1, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF);
        check_eq("rd_stall", 64'(n_stall), 64'd2);
        check_eq("rd_req",   64'(n_req),   64'd1);
        check_eq("rd_valid", 64'(n_valid), 64'd1);
        check_eq("rd_err",   64'(n_err),   64'd0);
        check_eq("rd_hold",  64'(n_bad),   64'd0);
        check_eq("rd_flush", 64'(n_flush), 64'd0);
        check_eq("rd_rdata", 64'(rdata),   64'hDEAD_BEEF);

        run_op(1'b0, 32'h0000_0040, 32'h1234_5678, 4, 32'h55AA_55AA);
        check_eq("wr_stall", 64'(n_stall), 64'd5);
        check_eq("wr_req",   64'(n_req),   64'd4);
        check_eq("wr_valid", 64'(n_valid), 64'd0);
        check_eq("wr_err",   64'(n_err),   64'd0);
        check_eq("wr_hold",  64'(n_bad),   64'd0);
        check_eq("wr_rdata", 64'(rdata),   64'hDEAD_BEEF);

        run_op(1'b1, 32'h0000_0080, 32'h0, 0, 32'hCAFE_F00D);
        check_eq("to_stall", 64'(n_stall), 64'd16);
        check_eq("to_req",   64'(n_req),   64'd15);
        check_eq("to_err",   64'(n_err),   64'd1);
        check_eq("to_valid", 64'(n_valid), 64'd0);
        check_eq("to_rdata", 64'(rdata),   64'hDEAD_BEEF);

        run_op(1'b1, 32'h0000_0084, 32'h0, 2, 32'h0BAD_F00D);
        check_eq("nx_stall", 64'(n_stall), 64'd3);
        check_eq("nx_req",   64'(n_req),   64'd2);
        check_eq("nx_valid", 64'(n_valid), 64'd1);
        check_eq("nx_rdata", 64'(rdata),   64'h0BAD_F00D);

        Branch = 1'b1; Zero = 1'b1; #1;
        check_eq("br_taken_flush", 64'(flush), 64'd1);
        check_eq("br_taken_stall", 64'(stall), 64'd0);
        Zero = 1'b0; #1;
        check_eq("br_nz_flush", 64'(flush), 64'd0);
        Zero = 1'b1; MemRead = 1'b1; #1;
        check_eq("br_memop_flush", 64'(flush), 64'd0);
        MemRead = 1'b0; Branch = 1'b0; Zero = 1'b0;
        step();

        MemRead = 1'b1; MemWrite = 1'b1;
        @(negedge clk);
        check_eq("ill_stall", 64'(stall),   64'd0);
        check_eq("ill_req0",  64'(mem_req), 64'd0);
        check_eq("ill_err0",  64'(mem_err), 64'd0);
        step();
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        check_eq("ill_err1", 64'(mem_err), 64'd1);
        check_eq("ill_req1", 64'(mem_req), 64'd0);
        step();
        @(negedge clk);
        check_eq("ill_err2", 64'(mem_err), 64'd0);
        step();

        MemRead = 1'b1; addr = 32'h0000_0200;
        step();
        @(negedge clk);
        check_eq("rm_req_a1", 64'(mem_req), 64'd1);
        step();
        reset = 1'b1;
        @(negedge clk);
        check_eq("rm_req_a2", 64'(mem_req), 64'd1);
        step();
        reset = 1'b0; MemRead = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        Branch = 1'b1; Zero = 1'b1;
        @(negedge clk);
        check_eq("rm_req",   64'(mem_req),     64'd0);
        check_eq("rm_stall", 64'(stall),       64'd0);
        check_eq("rm_idle",  64'(flush),       64'd1);
        check_eq("rm_err",   64'(mem_err),     64'd0);
        check_eq("rm_valid", 64'(rdata_valid), 64'd0);
        step();
        mem_ack = 1'b0; Branch = 1'b0; Zero = 1'b0;
        @(negedge clk);
        check_eq("rm_valid2", 64'(rdata_valid), 64'd0);
        check_eq("rm_err2",   64'(mem_err),     64'd0);
        check_eq("rm_rdata",  64'(rdata),       64'd0);
        check_eq("rm_req2",   64'(mem_req),     64'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
